// File: rtl/generic_adc_recorder.sv
// rtl/generic_adc_recorder.sv - triggered ADC beat recorder with GPIO CSR and sample readback
// Optional build macro GENERIC_ADC_RECORDER_TIMESTAMP_EN adds a trigger timestamp readable via gpioData[31].
module generic_adc_recorder #(
  parameter int BUS_WIDTH         = 32,
  parameter int AXIS_DATA_WIDTH   = 256,
  parameter int ADC_DATA_WIDTH    = 16,
  parameter int ADC_ADDRESS_WIDTH = 14
) (
  input  logic                       axis_CLK,
  input  logic                       axis_ARESETN,
  input  logic [BUS_WIDTH-1:0]       gpioData,
  input  logic                       gpioCsrStrobe,
  input  logic                       gpioAddressStrobe,
  output logic [BUS_WIDTH-1:0]       gpioCsr,
  output logic [BUS_WIDTH-1:0]       gpioReadData,
  input  logic                       trigger,
  input  logic [AXIS_DATA_WIDTH-1:0] axis_TDATA,
  input  logic                       axis_TVALID,
  output logic                       axis_TREADY
);

  localparam int SPW    = AXIS_DATA_WIDTH / ADC_DATA_WIDTH;
  localparam int LANE_W = $clog2(SPW);
  localparam int WAW    = ADC_ADDRESS_WIDTH - LANE_W;
  localparam int DEPTH  = 1 << WAW;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_e;

  state_e                       state_q, state_d;
  logic                         trig_q;
  logic                         tready_q;
  logic [WAW-1:0]               last_idx_q;
  logic [WAW-1:0]               write_idx_q;
  logic [ADC_ADDRESS_WIDTH-1:0] read_addr_q;
  logic [LANE_W-1:0]            lane_q;
  logic [BUS_WIDTH-1:0]         read_data_q, read_data_d;
  logic [AXIS_DATA_WIDTH-1:0]   rd_word_q;
  logic [AXIS_DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                         arm_cmd, abort_cmd, trig_edge;
  logic                         beat_we, idx_clear;
  logic [BUS_WIDTH-1:0]         csr_d;
  logic [ADC_ADDRESS_WIDTH-1:0] rd_addr;
  logic                         unused_bits;

  assign arm_cmd   = gpioCsrStrobe & gpioData[0];
  assign abort_cmd = gpioCsrStrobe & gpioData[1];
  // An edge coinciding with an arm write is deliberately dropped.
  assign trig_edge = trigger & ~trig_q & ~arm_cmd;

  // The read path follows the strobed address in the same cycle so data lands two cycles later.
  assign rd_addr     = gpioAddressStrobe ? gpioData[ADC_ADDRESS_WIDTH-1:0] : read_addr_q;
  assign unused_bits = ^gpioData;

  always_ff @(posedge axis_CLK or negedge axis_ARESETN) begin
    if (!axis_ARESETN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (arm_cmd) state_d = S_ARMED;
      S_ARMED:   if (trig_edge) state_d = S_CAPTURE;
      S_CAPTURE: if (axis_TVALID && (write_idx_q == last_idx_q)) state_d = S_DONE;
      S_DONE:    if (arm_cmd) state_d = S_ARMED;
      default:   state_d = S_IDLE;
    endcase
    if (abort_cmd) state_d = S_IDLE;
  end

  always_comb begin
    beat_we = 1'b0;
    csr_d   = '0;
    case (state_q)
      S_ARMED:   csr_d[0] = 1'b1;
      S_CAPTURE: begin
        csr_d[1] = 1'b1;
        beat_we  = axis_TVALID;
      end
      S_DONE:    csr_d[2] = 1'b1;
      default:   ;
    endcase
    csr_d[16 +: WAW] = last_idx_q;
    idx_clear = (state_q == S_ARMED) && (state_d == S_CAPTURE);
  end

  always_ff @(posedge axis_CLK or negedge axis_ARESETN) begin
    if (!axis_ARESETN) begin
      trig_q      <= 1'b0;
      tready_q    <= 1'b0;
      last_idx_q  <= '0;
      write_idx_q <= '0;
      read_addr_q <= '0;
      lane_q      <= '0;
      read_data_q <= '0;
    end else begin
      trig_q      <= trigger;
      tready_q    <= 1'b1;
      read_addr_q <= rd_addr;
      lane_q      <= rd_addr[LANE_W-1:0];
      read_data_q <= read_data_d;
      if (gpioCsrStrobe) last_idx_q <= gpioData[16 +: WAW];
      // The index parks on the final beat instead of wrapping back to word 0.
      if (idx_clear) begin
        write_idx_q <= '0;
      end else if (beat_we && (write_idx_q != last_idx_q)) begin
        write_idx_q <= write_idx_q + 1'b1;
      end
    end
  end

  // Buffer is intentionally not reset so a capture survives a reset for readback.
  always_ff @(posedge axis_CLK) begin
    if (beat_we) mem_q[write_idx_q] <= axis_TDATA;
    rd_word_q <= mem_q[rd_addr[ADC_ADDRESS_WIDTH-1:LANE_W]];
  end

`ifdef GENERIC_ADC_RECORDER_TIMESTAMP_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] trig_stamp_q;
  logic        ts_sel_q;

  always_ff @(posedge axis_CLK or negedge axis_ARESETN) begin
    if (!axis_ARESETN) begin
      cycle_cnt_q  <= '0;
      trig_stamp_q <= '0;
      ts_sel_q     <= 1'b0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (idx_clear) trig_stamp_q <= cycle_cnt_q;
      if (gpioAddressStrobe) ts_sel_q <= gpioData[31];
    end
  end

  always_comb begin
    read_data_d = BUS_WIDTH'(rd_word_q[lane_q*ADC_DATA_WIDTH +: ADC_DATA_WIDTH]);
    if (ts_sel_q) read_data_d = BUS_WIDTH'(trig_stamp_q);
  end
`else
  always_comb begin
    read_data_d = BUS_WIDTH'(rd_word_q[lane_q*ADC_DATA_WIDTH +: ADC_DATA_WIDTH]);
  end
`endif

  assign gpioCsr      = csr_d;
  assign gpioReadData = read_data_q;
  assign axis_TREADY  = tready_q;

endmodule

// File: tb/tb_generic_adc_recorder.sv
// tb/tb_generic_adc_recorder.sv - scoreboard bench for generic_adc_recorder with a spec-level reference model
module tb_generic_adc_recorder;
  localparam int BW = 32, AW = 256, DW = 16, SPW = 16, WAW = 10, DEPTH = 1024;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [BW-1:0] gpioData = '0, gpioCsr, gpioReadData;
  logic          gpioCsrStrobe = 1'b0, gpioAddressStrobe = 1'b0, trigger = 1'b0;
  logic [AW-1:0] axis_TDATA = '0;
  logic          axis_TVALID = 1'b0, axis_TREADY;

  always #5 clk = ~clk;

  generic_adc_recorder dut (
    .axis_CLK(clk), .axis_ARESETN(rst_n), .gpioData(gpioData), .gpioCsrStrobe(gpioCsrStrobe),
    .gpioAddressStrobe(gpioAddressStrobe), .gpioCsr(gpioCsr), .gpioReadData(gpioReadData),
    .trigger(trigger), .axis_TDATA(axis_TDATA), .axis_TVALID(axis_TVALID), .axis_TREADY(axis_TREADY)
  );

  int n_tests = 0, n_fail = 0;

  // Reference model: 0 idle, 1 armed, 2 capture, 3 done
  logic [AW-1:0] ref_mem [DEPTH];
  int            m_state = 0, m_widx = 0, m_last = 0;
  bit            m_tprev = 0;
  int unsigned   m_cnt = 0, m_stamp = 0;
  logic [BW-1:0] exp_q [$];
  bit            pend1 = 0, pend2 = 0;
  logic [BW-1:0] mon_exp;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    pend2 <= pend1;
    pend1 <= gpioAddressStrobe;
  end

  always @(negedge clk) begin
    if (pend2) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL readback: got %h with no expected value queued", gpioReadData);
      end else begin
        mon_exp = exp_q.pop_front();
        check("readback", gpioReadData, mon_exp);
      end
    end
  end

  function automatic logic [BW-1:0] exp_csr();
    logic [BW-1:0] c;
    c = '0;
    if (m_state == 1) c[0] = 1'b1;
    if (m_state == 2) c[1] = 1'b1;
    if (m_state == 3) c[2] = 1'b1;
    c[16 +: WAW] = m_last[WAW-1:0];
    return c;
  endfunction

  // One clock: update the model from the inputs currently driven, then step the DUT and check status.
  task automatic cycle();
    bit            arm, abort, edg, rd;
    int            a, ns;
    logic [AW-1:0] w;
    logic [BW-1:0] e;
    arm   = gpioCsrStrobe && gpioData[0];
    abort = gpioCsrStrobe && gpioData[1];
    edg   = trigger && !m_tprev;
    rd    = gpioAddressStrobe;
    e     = '0;
    if (rd) begin
      a = int'(gpioData[13:0]);
      w = ref_mem[a / SPW];
      e = BW'(w[(a % SPW) * DW +: DW]);
    end
    ns = m_state;
    case (m_state)
      0: if (arm) ns = 1;
      1: if (edg && !arm && !abort) begin ns = 2; m_widx = 0; m_stamp = m_cnt; end
      2: if (axis_TVALID) begin
           ref_mem[m_widx] = axis_TDATA;
           if (m_widx == m_last) ns = 3; else m_widx++;
         end
      3: if (arm) ns = 1;
      default: ns = 0;
    endcase
    if (abort) ns = 0;
    if (gpioCsrStrobe) m_last = int'(gpioData[16 +: WAW]);
    m_state = ns;
    m_tprev = trigger;
`ifdef GENERIC_ADC_RECORDER_TIMESTAMP_EN
    if (rd && gpioData[31]) e = BW'(m_stamp);
`endif
    if (rd) exp_q.push_back(e);
    m_cnt++;
    @(posedge clk);
    #1;
    check("csr", gpioCsr, exp_csr());
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic csr_wr(input bit arm, input bit abort, input int last);
    gpioData = '0;
    gpioData[0] = arm;
    gpioData[1] = abort;
    gpioData[16 +: WAW] = last[WAW-1:0];
    gpioCsrStrobe = 1'b1;
    cycle();
    gpioCsrStrobe = 1'b0;
    gpioData = '0;
  endtask

  task automatic pulse_trig();
    trigger = 1'b1;
    cycle();
    trigger = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_beat(input logic [15:0] lane0);
    logic [AW-1:0] b;
    for (int i = 0; i < AW / 32; i++) b[i*32 +: 32] = $urandom;
    b[15:0] = lane0;
    return b;
  endfunction

  task automatic beat(input bit v, input logic [AW-1:0] d);
    axis_TVALID = v;
    axis_TDATA  = d;
    cycle();
    axis_TVALID = 1'b0;
  endtask

  task automatic rd(input int addr, input bit b31);
    gpioData = BW'(addr);
    gpioData[31] = b31;
    gpioAddressStrobe = 1'b1;
    cycle();
    gpioAddressStrobe = 1'b0;
    gpioData = '0;
  endtask

  task automatic rd_rand(input int hi_word, input int n);
    for (int i = 0; i < n; i++) rd($urandom_range(hi_word * SPW + SPW - 1, 0), 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_csr", gpioCsr, '0);
    check("reset_rdata", gpioReadData, '0);
    check("reset_tready", BW'(axis_TREADY), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_state = 0; m_widx = 0; m_last = 0; m_tprev = 0; m_cnt = 0; m_stamp = 0;
  endtask

  int pat [7] = '{1, 0, 0, 1, 1, 0, 1};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    cycle();
    check("tready_after_reset", BW'(axis_TREADY), BW'(1));

    // Basic capture of four beats
    csr_wr(1, 0, 3);
    idle(2);
    pulse_trig();
    for (int k = 0; k < 4; k++) beat(1, rand_beat(16'h1000 + 16'(k)));
    check("basic_done", gpioCsr, 32'h0003_0004);
    rd(0, 0); rd(16, 0); rd(32, 0); rd(48, 0);
    rd_rand(3, 4);
    idle(3);

    // TVALID gaps, then beats arriving in DONE are not stored
    csr_wr(1, 0, 3);
    pulse_trig();
    for (int k = 0; k < 7; k++) beat(pat[k] != 0, rand_beat(16'($urandom)));
    beat(1, rand_beat(16'hdead));
    rd_rand(3, 6);
    idle(3);

    // Arm with a simultaneous trigger edge stays armed; edges during capture are ignored
    gpioData = '0; gpioData[0] = 1'b1; gpioData[16 +: WAW] = 10'd5;
    gpioCsrStrobe = 1'b1; trigger = 1'b1;
    cycle();
    gpioCsrStrobe = 1'b0; trigger = 1'b0; gpioData = '0;
    idle(2);
    pulse_trig();
    for (int k = 0; k < 6; k++) begin
      trigger = (k % 2) == 0;
      beat(1, rand_beat(16'($urandom)));
    end
    trigger = 1'b0;
    rd_rand(5, 8);
    idle(3);

    // Abort at beat 2 of 8
    csr_wr(1, 0, 7);
    pulse_trig();
    beat(1, rand_beat(16'h2000));
    beat(1, rand_beat(16'h2001));
    csr_wr(0, 1, 7);
    idle(2);
    pulse_trig();
    rd(0, 0); rd(16, 0); rd_rand(5, 3);
    idle(3);

    // Reset mid-capture keeps the buffer
    csr_wr(1, 0, 7);
    pulse_trig();
    beat(1, rand_beat(16'h3000));
    beat(1, rand_beat(16'h3001));
    do_reset();
    idle(2);
    pulse_trig();
    beat(1, rand_beat(16'hbeef));
    rd(0, 0); rd(17, 0); rd_rand(5, 3);
    idle(3);

    // lastIdx = 0 records exactly one beat
    csr_wr(1, 0, 0);
    pulse_trig();
    for (int k = 0; k < 3; k++) beat(1, rand_beat(16'h4000 + 16'(k)));
    rd(0, 0); rd(16, 0); rd(35, 0);
    idle(3);

    // Full depth, with read-before-write samples taken mid-capture
    csr_wr(1, 0, DEPTH - 1);
    pulse_trig();
    for (int k = 0; k < DEPTH; k++) begin
      if (k == 1 || k == 3 || k == 5) begin
        gpioData = BW'(k * SPW + 2);
        gpioAddressStrobe = 1'b1;
      end
      beat(1, rand_beat(16'($urandom)));
      gpioAddressStrobe = 1'b0;
      gpioData = '0;
    end
    beat(1, rand_beat(16'h5555));
    beat(1, rand_beat(16'h6666));
    rd(0, 0); rd((DEPTH - 1) * SPW, 0); rd((DEPTH - 1) * SPW + 15, 0);
    rd(7, 1);
    rd_rand(DEPTH - 1, 10);
    idle(4);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d outstanding expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
